// File: rtl/mpi_link_arbiter_if.sv
// Requester-side and MPI-send-side bundle of the link arbiter.
// The arbiter takes the slave modport; the NoC/DPI glue takes the master modport.
interface mpi_link_arbiter_if #(
  parameter int NUM_PORTS = 3,
  parameter int DATA_W    = 64
);
  localparam int PW = $clog2(NUM_PORTS);

  logic [NUM_PORTS-1:0]        req_valid_i;
  logic [NUM_PORTS*DATA_W-1:0] req_data_i;
  logic [NUM_PORTS-1:0]        req_ready_o;
  logic [NUM_PORTS-1:0]        yummy_i;
  logic                        send_valid_o;
  logic [DATA_W-1:0]           send_data_o;
  logic [PW-1:0]               send_port_o;

  modport master (
    output req_valid_i, req_data_i, yummy_i,
    input  req_ready_o, send_valid_o, send_data_o, send_port_o
  );

  modport slave (
    input  req_valid_i, req_data_i, yummy_i,
    output req_ready_o, send_valid_o, send_data_o, send_port_o
  );
endinterface

// File: rtl/mpi_link_arbiter.sv
// Round-robin arbiter sharing one MPI send channel among NUM_PORTS requesters, with
// per-port yummy credits and an idle/run/drain/done lifecycle. Optional MPI_LINK_ARB_ERR_EN adds err_o/err_port_o.

// Per-port credit counter: grant consumes, yummy returns, saturating at CREDITS.
module mpi_link_arbiter_credit #(
  parameter int CREDITS = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       take_i,
  input  logic       give_i,
  output logic [3:0] credit_o,
  output logic       full_o,
  output logic       nz_o
);
  localparam logic [3:0] MAX = 4'(CREDITS);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      credit_o <= MAX;
    else if (take_i && !give_i)
      credit_o <= credit_o - 4'd1;
    else if (give_i && !take_i && credit_o != MAX)
      credit_o <= credit_o + 4'd1;
  end

  assign full_o = (credit_o == MAX);
  assign nz_o   = (credit_o != 4'd0);
endmodule

module mpi_link_arbiter #(
  parameter int NUM_PORTS = 3,
  parameter int DATA_W    = 64,
  parameter int CREDITS   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  finalize_i,
  mpi_link_arbiter_if.slave     lnk,
  output logic [1:0]            state_o,
  output logic                  done_o
`ifdef MPI_LINK_ARB_ERR_EN
  ,
  output logic                  err_o,
  output logic [$clog2(NUM_PORTS)-1:0] err_port_o
`endif
);
  localparam int PW = $clog2(NUM_PORTS);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_e;

  state_e               state_q, state_d;
  logic                 grant_en, yummy_en;
  logic [PW-1:0]        ptr_q;
  logic [NUM_PORTS-1:0] elig, grant, yummy_act, cred_full, cred_nz;
  logic [PW-1:0]        gnt_idx;
  logic                 gnt_any;
  logic [NUM_PORTS-1:0][3:0] credit;

  // ---------------- FSM ----------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (finalize_i) state_d = DONE;
             else if (start_i) state_d = RUN;
      RUN:   if (finalize_i) state_d = DRAIN;
      DRAIN: if (&cred_full && !lnk.send_valid_o) state_d = DONE;
      DONE:  state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_en = (state_q == RUN);
    yummy_en = (state_q != IDLE);
    done_o   = (state_q == DONE);
    state_o  = state_q;
  end

  // ---------------- credits ----------------
  assign yummy_act = lnk.yummy_i & {NUM_PORTS{yummy_en}};

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_cred
    mpi_link_arbiter_credit #(.CREDITS(CREDITS)) u_cred (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .take_i   (grant[p]),
      .give_i   (yummy_act[p]),
      .credit_o (credit[p]),
      .full_o   (cred_full[p]),
      .nz_o     (cred_nz[p])
    );
  end

  // ---------------- round-robin pick ----------------
  assign elig = lnk.req_valid_i & cred_nz & {NUM_PORTS{grant_en}};

  always_comb begin
    int idx;
    idx     = 0;
    grant   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!gnt_any && elig[idx]) begin
        gnt_any    = 1'b1;
        gnt_idx    = PW'(idx);
        grant[idx] = 1'b1;
      end
    end
  end

  assign lnk.req_ready_o = grant;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      ptr_q <= '0;
    else if (gnt_any)
      ptr_q <= (gnt_idx == PW'(NUM_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
  end

  // ---------------- registered send stage ----------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lnk.send_valid_o <= 1'b0;
      lnk.send_data_o  <= '0;
      lnk.send_port_o  <= '0;
    end else begin
      lnk.send_valid_o <= gnt_any;
      if (gnt_any) begin
        lnk.send_data_o <= lnk.req_data_i[int'(gnt_idx)*DATA_W +: DATA_W];
        lnk.send_port_o <= gnt_idx;
      end
    end
  end

`ifdef MPI_LINK_ARB_ERR_EN
  // A requester must hold valid until granted; a yummy on a full counter is a protocol slip.
  logic [NUM_PORTS-1:0] valid_q, ready_q, drop, ovf, off;
  logic [PW-1:0]        off_idx;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      ready_q <= '0;
    end else begin
      valid_q <= lnk.req_valid_i;
      ready_q <= grant;
    end
  end

  assign drop = valid_q & ~ready_q & ~lnk.req_valid_i;
  assign ovf  = yummy_act & ~grant & cred_full;
  assign off  = drop | ovf;

  always_comb begin
    off_idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--)
      if (off[i]) off_idx = PW'(i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_o      <= 1'b0;
      err_port_o <= '0;
    end else if (!err_o && |off) begin
      err_o      <= 1'b1;
      err_port_o <= off_idx;
    end
  end
`endif
endmodule

// File: tb/tb_mpi_link_arbiter.sv
// Directed bench for mpi_link_arbiter: round-robin, credits, drain, finalize-in-idle, mid-stream reset.
module tb_mpi_link_arbiter;
  localparam int NP = 3;
  localparam int DW = 64;
  localparam int CR = 4;

  logic       clk_i = 1'b0;
  logic       rst_i, start_i, finalize_i;
  logic [1:0] state_o;
  logic       done_o;
`ifdef MPI_LINK_ARB_ERR_EN
  logic       err_o;
  logic [1:0] err_port_o;
`endif
  int vecs = 0;
  int errs = 0;

  mpi_link_arbiter_if #(.NUM_PORTS(NP), .DATA_W(DW)) lnk ();

  mpi_link_arbiter #(.NUM_PORTS(NP), .DATA_W(DW), .CREDITS(CR)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .finalize_i (finalize_i),
    .lnk        (lnk),
    .state_o    (state_o),
    .done_o     (done_o)
`ifdef MPI_LINK_ARB_ERR_EN
    ,
    .err_o      (err_o),
    .err_port_o (err_port_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset;
    rst_i = 1'b1; start_i = 1'b0; finalize_i = 1'b0;
    lnk.req_valid_i = '0; lnk.req_data_i = '0; lnk.yummy_i = '0;
    tick(); tick();
    rst_i = 1'b0;
  endtask

  // Runs n cycles with the current inputs and counts cycles carrying a grant.
  task automatic count_grants(input int n, output int g);
    g = 0;
    repeat (n) begin
      #1;
      if (|lnk.req_ready_o) g++;
      tick();
    end
  endtask

  task automatic test_reset;
    rst_i = 1'b1; start_i = 1'b1; finalize_i = 1'b0;
    lnk.req_valid_i = 3'b111; lnk.req_data_i = '1; lnk.yummy_i = '0;
    tick(); tick();
    vecs++; if (state_o !== 2'd0) begin errs++; $display("FAIL reset_state got %0d want 0", state_o); end
    vecs++; if (lnk.send_valid_o !== 1'b0) begin errs++; $display("FAIL reset_send_valid got %b want 0", lnk.send_valid_o); end
    vecs++; if (lnk.send_data_o !== 64'd0) begin errs++; $display("FAIL reset_send_data got %h want 0", lnk.send_data_o); end
    vecs++; if (lnk.send_port_o !== 2'd0) begin errs++; $display("FAIL reset_send_port got %0d want 0", lnk.send_port_o); end
    vecs++; if (done_o !== 1'b0) begin errs++; $display("FAIL reset_done got %b want 0", done_o); end
    vecs++; if (lnk.req_ready_o !== 3'b000) begin errs++; $display("FAIL reset_ready got %b want 000", lnk.req_ready_o); end
  endtask

  task automatic test_round_robin;
    logic [DW-1:0] exp_d;
    do_reset();
    start_i = 1'b1; lnk.req_valid_i = 3'b111;
    tick();
    vecs++; if (state_o !== 2'd1) begin errs++; $display("FAIL rr_state got %0d want 1", state_o); end
    for (int k = 0; k < 12; k++) begin
      for (int p = 0; p < NP; p++)
        lnk.req_data_i[p*DW +: DW] = {32'hD00D0000 + 32'(k), 32'(p)};
      exp_d = {32'hD00D0000 + 32'(k), 32'(k % 3)};
      #1;
      vecs++; if (lnk.req_ready_o !== 3'(1 << (k % 3))) begin errs++; $display("FAIL rr_ready[%0d] got %b want %b", k, lnk.req_ready_o, 3'(1 << (k % 3))); end
      tick();
      vecs++; if (lnk.send_valid_o !== 1'b1 || lnk.send_port_o !== 2'(k % 3) || lnk.send_data_o !== exp_d) begin
        errs++; $display("FAIL rr_send[%0d] got v=%b p=%0d d=%h want v=1 p=%0d d=%h", k, lnk.send_valid_o, lnk.send_port_o, lnk.send_data_o, k % 3, exp_d);
      end
    end
    for (int k = 0; k < 3; k++) begin
      #1;
      vecs++; if (lnk.req_ready_o !== 3'b000) begin errs++; $display("FAIL rr_no_credit_ready[%0d] got %b want 000", k, lnk.req_ready_o); end
      tick();
      vecs++; if (lnk.send_valid_o !== 1'b0) begin errs++; $display("FAIL rr_no_credit_send[%0d] got %b want 0", k, lnk.send_valid_o); end
    end
  endtask

  task automatic test_yummy_stream;
    int g;
    do_reset();
    start_i = 1'b1; lnk.req_valid_i = 3'b010;
    tick();
    for (int k = 0; k < 8; k++) begin
      lnk.yummy_i = (k >= 1) ? 3'b010 : 3'b000;
      #1;
      vecs++; if (lnk.req_ready_o !== 3'b010) begin errs++; $display("FAIL ystream_ready[%0d] got %b want 010", k, lnk.req_ready_o); end
      tick();
      vecs++; if (lnk.send_valid_o !== 1'b1 || lnk.send_port_o !== 2'd1) begin
        errs++; $display("FAIL ystream_send[%0d] got v=%b p=%0d want v=1 p=1", k, lnk.send_valid_o, lnk.send_port_o);
      end
    end
    lnk.req_valid_i = '0; lnk.yummy_i = '0;
    tick();
    lnk.req_valid_i = 3'b010;
    count_grants(6, g);
    vecs++; if (g !== 3) begin errs++; $display("FAIL ystream_credit_left got %0d want 3", g); end
  endtask

  task automatic test_same_cycle;
    int g;
    do_reset();
    start_i = 1'b1; lnk.req_valid_i = 3'b100;
    tick();
    for (int k = 0; k < 3; k++) begin
      lnk.yummy_i = (k == 2) ? 3'b100 : 3'b000;
      #1;
      vecs++; if (lnk.req_ready_o !== 3'b100) begin errs++; $display("FAIL same_ready[%0d] got %b want 100", k, lnk.req_ready_o); end
      tick();
    end
    lnk.yummy_i = '0; lnk.req_valid_i = '0;
    tick();
    lnk.req_valid_i = 3'b100;
    count_grants(6, g);
    vecs++; if (g !== 2) begin errs++; $display("FAIL same_cycle_credit got %0d want 2", g); end
  endtask

  task automatic test_saturate;
    int g;
    do_reset();
    start_i = 1'b1;
    tick();
    lnk.yummy_i = 3'b100;
    tick();
    lnk.yummy_i = '0;
`ifdef MPI_LINK_ARB_ERR_EN
    vecs++; if (err_o !== 1'b1 || err_port_o !== 2'd2) begin errs++; $display("FAIL sat_err got e=%b p=%0d want e=1 p=2", err_o, err_port_o); end
`endif
    lnk.req_valid_i = 3'b100;
    count_grants(6, g);
    vecs++; if (g !== 4) begin errs++; $display("FAIL sat_credit got %0d want 4", g); end
  endtask

  task automatic test_drain;
    logic [NP-1:0] yseq [5];
    yseq[0] = 3'b001; yseq[1] = 3'b010; yseq[2] = 3'b001; yseq[3] = 3'b010; yseq[4] = 3'b100;
    do_reset();
    start_i = 1'b1; lnk.req_valid_i = 3'b111;
    tick();
    repeat (5) tick();
    lnk.req_valid_i = '0; finalize_i = 1'b1;
    tick();
    vecs++; if (state_o !== 2'd2) begin errs++; $display("FAIL drain_state got %0d want 2", state_o); end
    lnk.req_valid_i = 3'b111; finalize_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      lnk.yummy_i = yseq[k];
      #1;
      vecs++; if (lnk.req_ready_o !== 3'b000) begin errs++; $display("FAIL drain_ready[%0d] got %b want 000", k, lnk.req_ready_o); end
      tick();
      vecs++; if (lnk.send_valid_o !== 1'b0) begin errs++; $display("FAIL drain_send[%0d] got %b want 0", k, lnk.send_valid_o); end
      if (k == 3) begin
        vecs++; if (state_o !== 2'd2) begin errs++; $display("FAIL drain_hold got %0d want 2", state_o); end
      end
    end
    lnk.yummy_i = '0;
    tick();
    vecs++; if (state_o !== 2'd3 || done_o !== 1'b1) begin errs++; $display("FAIL drain_done got s=%0d d=%b want s=3 d=1", state_o, done_o); end
  endtask

  task automatic test_finalize_idle;
    do_reset();
    finalize_i = 1'b1; start_i = 1'b1; lnk.req_valid_i = 3'b111;
    tick();
    vecs++; if (state_o !== 2'd3 || done_o !== 1'b1) begin errs++; $display("FAIL fin_idle_state got s=%0d d=%b want s=3 d=1", state_o, done_o); end
    finalize_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      vecs++; if (lnk.req_ready_o !== 3'b000) begin errs++; $display("FAIL fin_idle_ready[%0d] got %b want 000", k, lnk.req_ready_o); end
      tick();
      vecs++; if (lnk.send_valid_o !== 1'b0) begin errs++; $display("FAIL fin_idle_send[%0d] got %b want 0", k, lnk.send_valid_o); end
    end
    vecs++; if (done_o !== 1'b1) begin errs++; $display("FAIL fin_idle_sticky got %b want 1", done_o); end
  endtask

  task automatic test_reset_midstream;
    int g;
    do_reset();
    start_i = 1'b1; lnk.req_valid_i = 3'b111;
    tick(); tick();
    vecs++; if (lnk.send_valid_o !== 1'b1) begin errs++; $display("FAIL mid_pre_send got %b want 1", lnk.send_valid_o); end
    #2 rst_i = 1'b1;
    #1;
    vecs++; if (lnk.send_valid_o !== 1'b0) begin errs++; $display("FAIL mid_async_send got %b want 0", lnk.send_valid_o); end
    vecs++; if (state_o !== 2'd0) begin errs++; $display("FAIL mid_async_state got %0d want 0", state_o); end
    tick();
    rst_i = 1'b0;
    count_grants(17, g);
    vecs++; if (g !== 12) begin errs++; $display("FAIL mid_credits got %0d grants want 12", g); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_yummy_stream();
    test_same_cycle();
    test_saturate();
    test_drain();
    test_finalize_idle();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/mpi_link_arbiter.md
Name: mpi_link_arbiter

Overview:
- Shares one rank-to-rank MPI data channel among NUM_PORTS local NoC requesters.
- Uses round-robin arbitration with yummy-credit flow control per port.
- Sequences the channel lifecycle: idle, run, credit drain on finalize, done.
- Sits between the fake-node NoC ports and the DPI-C send/receive glue. The glue calls the send function when send_valid_o is high and pulses yummy_i when credits return.

Parameters:
- NUM_PORTS, 3, number of requester ports (2..8).
- DATA_W, 64, flit width in bits.
- CREDITS, 4, initial and maximum credit count per port (1..15).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- start_i  in  1  MPI initialized and rank valid; level-sensitive
- finalize_i  in  1  request orderly shutdown; level-sensitive
- req_valid_i  in  NUM_PORTS  per-port flit valid
- req_data_i  in  NUM_PORTS*DATA_W  per-port flit; port p occupies bits [p*DATA_W +: DATA_W]
- req_ready_o  out  NUM_PORTS  one-hot grant (combinational)
- yummy_i  in  NUM_PORTS  per-port credit return pulse, one credit per cycle high
- send_valid_o  out  1  registered: flit presented to MPI send this cycle
- send_data_o  out  DATA_W  registered granted flit
- send_port_o  out  $clog2(NUM_PORTS)  registered source port index
- state_o  out  2  FSM state encoding
- done_o  out  1  drain complete; sticky until reset

Behaviour:
- Reset (async on rst_i rising edge, held while high):
  - state = IDLE; all credits = CREDITS; round-robin pointer = 0.
  - send_valid_o = 0, send_data_o = 0, send_port_o = 0, done_o = 0, req_ready_o = 0.
- FSM states: IDLE = 0, RUN = 1, DRAIN = 2, DONE = 3.
  - IDLE: finalize_i has priority and moves to DONE. Otherwise start_i moves to RUN. No grants.
  - RUN: finalize_i moves to DRAIN. The grant in the cycle finalize_i is sampled high still completes.
  - DRAIN: no new grants. Moves to DONE in the first cycle where every credit equals CREDITS and send_valid_o is 0.
  - DONE: no grants; done_o = 1. Only reset exits.
- Eligibility and grant:
  - Port p is eligible when req_valid_i[p] = 1, credit[p] > 0 and state == RUN.
  - At most one grant per cycle. Search starts at the pointer and wraps modulo NUM_PORTS; the first eligible port wins.
  - req_ready_o[p] = 1 for the winner only. A handshake is valid & ready in the same cycle.
  - On a grant to p: pointer <= (p+1) mod NUM_PORTS. With no grant, the pointer holds.
- Latency: the cycle after a grant, send_valid_o = 1, send_data_o = the flit, send_port_o = p.
  - With no grant, send_valid_o = 0 and data/port hold their last values.
- Credit counters, width 4 bits each:
  - Grant only: decrement.
  - yummy_i only: increment.
  - Grant and yummy_i on the same port in the same cycle: unchanged.
  - yummy_i at credit == CREDITS: saturate at CREDITS; the overflow is dropped.
  - credit == 0: port ineligible, req_ready_o[p] = 0. The requester holds its flit.
- yummy_i is honoured in every state except IDLE-before-start. This lets DRAIN collect outstanding credits.
- Reset mid-operation: all state is discarded immediately, including an in-flight send_valid_o. Credits return to CREDITS.

Optional Feature:
- Macro: MPI_LINK_ARB_ERR_EN.
- Defined:
  - Adds output err_o (1 bit): sticky, set the cycle after any yummy_i overflow at credit == CREDITS, or a req_valid_i drop while not granted. Cleared only by reset.
  - Adds output err_port_o ($clog2(NUM_PORTS)): the first offending port, latched.
- Undefined: neither port exists, and overflows are silently saturated.

Test Plan:
- Reset then start_i=1, req_valid_i=3'b111, no yummy:
  - Grants go 0,1,2,0,1,2,… until each port has had 4 grants (12 grants total).
  - req_ready_o then stays 0; send_port_o sequence lags the grants by 1 cycle.
- Only port 1 valid, with yummy_i[1] pulsed every cycle from the cycle after the first grant:
  - Port 1 is granted every cycle; its credit never drops below 3.
- Port 2 at credit 2, grant and yummy_i[2] in the same cycle → credit stays 2.
  - yummy_i[2] at credit 4 → stays 4; err_o = 1 next cycle with MPI_LINK_ARB_ERR_EN defined.
- In RUN with 5 flits outstanding, assert finalize_i:
  - state_o = 2, no further grants.
  - After 5 matching yummies, state_o = 3 and done_o = 1 on the following cycle.
- finalize_i=1 in IDLE → state_o = 3, done_o = 1, and send_valid_o never asserts.
- Assert rst_i mid-stream with send_valid_o = 1:
  - send_valid_o drops asynchronously; state_o = 0 and all credits read 4 after release.
